apb4_slave_mem_ws: RTL and testbench

APB4_SLAVE_MEM_WS -- requirements
Module: apb4_slave_mem_ws

---
 rtl/apb_pkg.sv | 22 ++
 rtl/sp_ram_be.sv | 41 ++++
 rtl/apb4_slave_mem_ws.sv | 169 ++++++++++++++++
 tb/tb_apb4_slave_mem_ws.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared FSM state type, wait-state limit and byte-lane helper
//
// Purpose : common definitions imported by the APB4 memory slave and its RAM.
// Contents: apb_state_t   - slave FSM states (IDLE, ACCESS)
//           WAIT_STATES_MAX - largest supported access-phase wait count
//           WAIT_CNT_W    - width of the wait-state down-counter
//           byte_lanes()  - number of byte lanes in a data word
package apb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_t;

  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned WAIT_CNT_W      = 4;

  function automatic int unsigned byte_lanes(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sp_ram_be.sv
// rtl/sp_ram_be.sv - single-port byte-enabled RAM, synchronous write, combinational read
//
// Purpose : word-addressed storage behind the APB slave. Contents are not
//           reset; only lanes whose byte enable is set are updated on a write.
// Ports   : clk   - write clock
//           we    - write enable (one-cycle commit pulse)
//           addr  - word index
//           wdata - write data
//           be    - byte-lane enables for the write
//           rdata - combinational read of mem[addr]
module sp_ram_be
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  localparam int unsigned LANES     = byte_lanes(DATA_WIDTH),
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [LANES-1:0]      be,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(LANES); i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb4_slave_mem_ws.sv
// rtl/apb4_slave_mem_ws.sv - APB4 slave with byte-strobed RAM and fixed wait states
//
// Purpose : APB4 completer in front of a sp_ram_be array. Every transfer takes
//           1 + WAIT_STATES access cycles; pready, prdata and pslverr are
//           registered and valid for exactly one cycle.
// Ports   : pclk     - clock, all state changes on the rising edge
//           presetn  - asynchronous active-low reset
//           paddr    - byte address
//           psel     - slave select
//           penable  - access-phase marker
//           pwrite   - 1 = write, 0 = read
//           pwdata   - write data
//           pstrb    - write byte strobes (ignored on reads)
//           pready   - transfer complete (registered)
//           prdata   - read data, zero outside the completing read cycle
//           pslverr  - error response, only with pready
module apb4_slave_mem_ws
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RAM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned ERR_ON_OOR  = 1
) (
  input  logic                              pclk,
  input  logic                              presetn,
  input  logic [ADDR_WIDTH-1:0]             paddr,
  input  logic                              psel,
  input  logic                              penable,
  input  logic                              pwrite,
  input  logic [DATA_WIDTH-1:0]             pwdata,
  input  logic [byte_lanes(DATA_WIDTH)-1:0] pstrb,
  output logic                              pready,
  output logic [DATA_WIDTH-1:0]             prdata,
  output logic                              pslverr
);

  localparam int unsigned LANES = byte_lanes(DATA_WIDTH);
  localparam int unsigned IDX_W = $clog2(RAM_DEPTH);
  localparam int unsigned LSB   = $clog2(LANES);
  localparam int unsigned WS    = (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX
                                                                  : WAIT_STATES;

  localparam logic [WAIT_CNT_W-1:0] WS_LOAD     = WAIT_CNT_W'(WS);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ADDR_WIDTH'(LANES - 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(RAM_DEPTH);
  localparam logic                  ERR_EN      = (ERR_ON_OOR != 0);
  localparam logic                  ZERO_WAIT   = (WS == 0);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  addr_misaligned;
  logic                  addr_oor;
  logic                  addr_bad;

  assign word_idx        = paddr >> LSB;
  assign addr_misaligned = (paddr & ALIGN_MASK) != '0;
  assign addr_oor        = word_idx >= DEPTH_LIMIT;
  assign addr_bad        = addr_misaligned | addr_oor;

  // ---------------------------------------------------------------------------
  // Memory
  // ---------------------------------------------------------------------------
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  sp_ram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (RAM_DEPTH)
  ) u_ram (
    .clk   (pclk),
    .we    (ram_we),
    .addr  (word_idx[IDX_W-1:0]),
    .wdata (pwdata),
    .be    (pstrb),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // FSM, wait counter and response registers
  // ---------------------------------------------------------------------------
  apb_state_t            state_q;
  apb_state_t            state_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_d;
  logic                  pready_d;
  logic                  pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  setup_phase;
  logic                  complete;

  // penable high in IDLE is not a setup phase, so a stray access phase is ignored
  assign setup_phase = psel & ~penable;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = '0;
    complete   = 1'b0;
    ram_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (setup_phase) begin
          state_d    = ST_ACCESS;
          wait_cnt_d = WS_LOAD;
          // With no wait states the response must already be up in the first
          // access cycle, so it is registered on the setup edge.
          complete   = ZERO_WAIT;
        end
      end

      ST_ACCESS: begin
        if (!psel) begin
          // Master abandoned the transfer: no commit, no response.
          state_d = ST_IDLE;
        end else if (pready) begin
          // Completion edge: commit the write unless the address is bad.
          state_d = ST_IDLE;
          ram_we  = pwrite & ~addr_bad;
        end else begin
          // The counter reads 1 in the last wait cycle; registering the
          // response there puts pready in the cycle where it reaches 0.
          complete = (wait_cnt_q <= WAIT_CNT_W'(1));
        end

        if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Read data is sampled one edge early; the memory cannot change in
    // between because commits only happen on a completion edge.
    if (complete) begin
      pready_d  = 1'b1;
      pslverr_d = addr_bad & ERR_EN;
      if (!pwrite && !addr_bad) begin
        prdata_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      pready     <= 1'b0;
      prdata     <= '0;
      pslverr    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pready     <= pready_d;
      prdata     <= prdata_d;
      pslverr    <= pslverr_d;
    end
  end

endmodule

// File: tb/tb_apb4_slave_mem_ws.sv
// tb/tb_apb4_slave_mem_ws.sv - scoreboard bench for apb4_slave_mem_ws
module tb_apb4_slave_mem_ws;

  localparam int NDUT = 3;

  logic            pclk = 1'b0;
  logic            presetn = 1'b0;
  logic [31:0]     paddr = '0;
  logic            penable = 1'b0;
  logic            pwrite = 1'b0;
  logic [31:0]     pwdata = '0;
  logic [3:0]      pstrb = '0;
  logic [NDUT-1:0] psel = '0;
  logic [NDUT-1:0] pready;
  logic [NDUT-1:0] pslverr;
  logic [31:0]     prdata [NDUT];

  always #5 pclk = ~pclk;

  // u_ws0: 0 wait states, errors on; u_ws3: 3 wait states; u_ws2: 2 wait states, silent
  apb4_slave_mem_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_DEPTH(256),
                      .WAIT_STATES(0), .ERR_ON_OOR(1)) u_ws0 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));

  apb4_slave_mem_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_DEPTH(256),
                      .WAIT_STATES(3), .ERR_ON_OOR(1)) u_ws3 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));

  apb4_slave_mem_ws #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RAM_DEPTH(256),
                      .WAIT_STATES(2), .ERR_ON_OOR(0)) u_ws2 (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .psel(psel[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          setup_cyc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] model [int];
  int          written [$];

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Monitor: every pready pops one expected response; otherwise outputs must be 0.
  always @(negedge pclk) begin
    exp_t e;
    if (presetn === 1'b1) begin
      for (int d = 0; d < NDUT; d++) begin
        if (pready[d] === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pready: dut %0d pready=1, expected no response", d);
          end else begin
            e = exp_q.pop_front();
            chk({e.name, "_dut"},     64'(d),                 64'(e.dut));
            chk({e.name, "_prdata"},  64'(prdata[d]),         64'(e.rdata));
            chk({e.name, "_pslverr"}, 64'(pslverr[d]),        64'(e.err));
            chk({e.name, "_latency"}, 64'(cyc - e.setup_cyc), 64'(e.lat));
          end
        end else begin
          chk("idle_prdata_zero",  64'(prdata[d]),  64'd0);
          chk("idle_pslverr_zero", 64'(pslverr[d]), 64'd0);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after pready, so a
  // following call issues its setup phase back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err,
                      input int lat, input string name);
    exp_t e;
    int   waited;
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    pstrb   = strb;
    e.dut = d; e.rdata = exp_rdata; e.err = exp_err; e.lat = lat;
    e.setup_cyc = cyc; e.name = name;
    exp_q.push_back(e);
    @(posedge pclk); #1;
    penable = 1'b1;
    waited  = 0;
    while (pready[d] !== 1'b1 && waited < 40) begin
      @(posedge pclk); #1;
      waited++;
    end
    if (pready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no pready after %0d cycles, expected latency %0d", name, waited, lat);
      e = exp_q.pop_back();
    end else begin
      @(posedge pclk); #1;
    end
    psel    = '0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  st;
    int          idx;

    // Reset state
    repeat (2) @(posedge pclk);
    #2;
    for (int d = 0; d < NDUT; d++) begin
      chk("reset_pready",  64'(pready[d]),  64'd0);
      chk("reset_prdata",  64'(prdata[d]),  64'd0);
      chk("reset_pslverr", 64'(pslverr[d]), 64'd0);
    end
    presetn = 1'b1;
    @(posedge pclk); #1;

    // Zero wait states: first setup after reset accepted, write then read
    xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, "ws0_wr10");
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, "ws0_rd10");

    // Byte strobes
    xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 1, "strb_wr_full");
    xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, 0, 1, "strb_wr_part");
    xfer(0, 0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 0, 1, "strb_rd");
    idle(2);

    // Errors with ERR_ON_OOR=1: 0x400 and 0x02 alias word 0 in the array
    xfer(0, 1, 32'h00, 32'h01020304, 4'hF, 32'h0, 0, 1, "err1_wr0");
    xfer(0, 1, 32'h400, 32'h99999999, 4'hF, 32'h0, 1, 1, "err1_wr_oor");
    xfer(0, 1, 32'h02, 32'h88888888, 4'hF, 32'h0, 1, 1, "err1_wr_mis");
    xfer(0, 0, 32'h400, 32'h0, 4'hF, 32'h0, 1, 1, "err1_rd_oor");
    xfer(0, 0, 32'h00, 32'h0, 4'hF, 32'h01020304, 0, 1, "err1_rd0");
    xfer(0, 1, 32'h3FC, 32'hFEEDFACE, 4'hF, 32'h0, 0, 1, "ws0_wr_last");
    xfer(0, 0, 32'h3FC, 32'h0, 4'hF, 32'hFEEDFACE, 0, 1, "ws0_rd_last");

    // penable without setup in IDLE is ignored
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    idle(2);
    psel = '0; penable = 1'b0;
    idle(1);
    xfer(0, 0, 32'h00, 32'h0, 4'hF, 32'h01020304, 0, 1, "stray_penable_rd0");

    // Three wait states
    xfer(1, 1, 32'h04, 32'h5A5A0001, 4'hF, 32'h0, 0, 4, "ws3_wr04");
    xfer(1, 0, 32'h04, 32'h0, 4'hF, 32'h5A5A0001, 0, 4, "ws3_rd04");
    xfer(1, 0, 32'h400, 32'h0, 4'hF, 32'h0, 1, 4, "ws3_rd_oor");
    idle(1);

    // Silent errors with ERR_ON_OOR=0, two wait states
    xfer(2, 1, 32'h00, 32'h0BADF00D, 4'hF, 32'h0, 0, 3, "err0_wr0");
    xfer(2, 1, 32'h400, 32'h99999999, 4'hF, 32'h0, 0, 3, "err0_wr_oor");
    xfer(2, 1, 32'h02, 32'h77777777, 4'hF, 32'h0, 0, 3, "err0_wr_mis");
    xfer(2, 0, 32'h400, 32'h0, 4'hF, 32'h0, 0, 3, "err0_rd_oor");
    xfer(2, 0, 32'h00, 32'h0, 4'hF, 32'h0BADF00D, 0, 3, "err0_rd0");

    // Abort: psel dropped in the first wait cycle of a write to 0x08
    xfer(2, 1, 32'h08, 32'h12345678, 4'hF, 32'h0, 0, 3, "abort_pre_wr");
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
    idle(5);
    xfer(2, 0, 32'h08, 32'h0, 4'hF, 32'h12345678, 0, 3, "abort_rd08");

    // Reset pulse during a wait cycle drops the pending write
    xfer(2, 1, 32'h0C, 32'hA5A5A5A5, 4'hF, 32'h0, 0, 3, "rst_pre_wr");
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
    pwdata = 32'h5A5A5A5A; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_wait_pready",  64'(pready[d]),  64'd0);
      chk("rst_wait_pslverr", 64'(pslverr[d]), 64'd0);
      chk("rst_wait_prdata",  64'(prdata[d]),  64'd0);
    end
    #4 presetn = 1'b1;
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(2, 0, 32'h0C, 32'h0, 4'hF, 32'hA5A5A5A5, 0, 3, "rst_post_rd0c");

    // Reset pulse in a pready cycle clears the outputs immediately
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("rst_rdy_pre_pready", 64'(pready[0]), 64'd1);
    chk("rst_rdy_pre_prdata", 64'(prdata[0]), 64'hDEADBEEF);
    #2 presetn = 1'b0;
    #1;
    chk("rst_rdy_pready", 64'(pready[0]), 64'd0);
    chk("rst_rdy_prdata", 64'(prdata[0]), 64'd0);
    #4 presetn = 1'b1;
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, 1, "rst_rdy_post_rd");

    // Ten back-to-back alternating write/read transfers
    for (int i = 0; i < 5; i++) begin
      idx = $urandom_range(0, 255);
      a   = 32'(idx) << 2;
      wd  = $urandom;
      st  = model.exists(idx) ? 4'($urandom_range(1, 15)) : 4'hF;
      model[idx] = model.exists(idx) ? merge(model[idx], wd, st) : wd;
      written.push_back(idx);
      xfer(0, 1, a, wd, st, 32'h0, 0, 1, "b2b_wr");
      if (i % 2 == 1) idx = written[$urandom_range(0, written.size() - 1)];
      xfer(0, 0, 32'(idx) << 2, 32'h0, 4'hF, model[idx], 0, 1, "b2b_rd");
    end

    idle(3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
